rv0_ahb_arb: RTL and testbench

- 2:1 AHB-Lite manager-side arbiter directly downstream of the core.
- Merges the core's instruction-fetch requester (IM) and data requester (DM) onto one AHB-Lite manager port (M) facing the system bus.
- Tracks address-phase and data-phase ownership separately so pipelined transfers of both requesters interleave correctly.
- Captures read data for a requester whose data phase completes while its next address phase is still stalled by arbitration.

---
 rtl/rv0_ahb_arb.sv | 255 +++++++++++++++++++++++++
 tb/tb_rv0_ahb_arb.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv0_ahb_arb.sv
// rv0_ahb_arb: 2:1 AHB-Lite manager-side arbiter merging the core's
// instruction-fetch (IM) and data (DM) requesters onto one manager port.
// Address-phase and data-phase ownership are tracked separately so the
// pipelined transfers of both requesters interleave without reordering.
// Read data that completes while the same requester's next address phase
// is still losing arbitration is parked until that requester sees hready.
module rv0_ahb_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter bit DMEM_PRIO  = 1'b1,
  parameter int STARVE_LIM = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] im_haddr_i,
  input  logic [1:0]            im_htrans_i,
  input  logic                  im_hwrite_i,
  input  logic [2:0]            im_hsize_i,
  input  logic [3:0]            im_hprot_i,
  input  logic [DATA_WIDTH-1:0] im_hwdata_i,
  output logic                  im_hready_o,
  output logic [DATA_WIDTH-1:0] im_hrdata_o,
  output logic                  im_hresp_o,
  input  logic [ADDR_WIDTH-1:0] dm_haddr_i,
  input  logic [1:0]            dm_htrans_i,
  input  logic                  dm_hwrite_i,
  input  logic [2:0]            dm_hsize_i,
  input  logic [3:0]            dm_hprot_i,
  input  logic [DATA_WIDTH-1:0] dm_hwdata_i,
  output logic                  dm_hready_o,
  output logic [DATA_WIDTH-1:0] dm_hrdata_o,
  output logic                  dm_hresp_o,
  output logic [ADDR_WIDTH-1:0] m_haddr_o,
  output logic [1:0]            m_htrans_o,
  output logic                  m_hwrite_o,
  output logic [2:0]            m_hsize_o,
  output logic [3:0]            m_hprot_o,
  output logic [DATA_WIDTH-1:0] m_hwdata_o,
  input  logic                  m_hready_i,
  input  logic [DATA_WIDTH-1:0] m_hrdata_i,
  input  logic                  m_hresp_i
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IM   = 2'b01,
    OWN_DM   = 2'b10
  } owner_e;

  localparam owner_e     PRIO_SIDE    = DMEM_PRIO ? OWN_DM : OWN_IM;
  localparam owner_e     OTHER_SIDE   = DMEM_PRIO ? OWN_IM : OWN_DM;
  localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_LIM);
  localparam logic [1:0] HTRANS_IDLE  = 2'b00;

  owner_e                aphase_q, aphase_d;
  owner_e                downer_q, downer_d;
  logic                  hold_im_q, hold_im_d;
  logic                  hold_dm_q, hold_dm_d;
  logic [DATA_WIDTH-1:0] cap_im_q, cap_im_d;
  logic [DATA_WIDTH-1:0] cap_dm_q, cap_dm_d;
  logic                  cap_resp_im_q, cap_resp_im_d;
  logic                  cap_resp_dm_q, cap_resp_dm_d;
  logic [3:0]            starve_q, starve_d;

  logic   req_im_s, req_dm_s, req_other_s;
  logic   idle_im_s, idle_dm_s;
  logic   im_hready_s, dm_hready_s;
  logic   set_hold_im_s, set_hold_dm_s;
  owner_e sel_s;

  assign req_im_s    = im_htrans_i[1];
  assign req_dm_s    = dm_htrans_i[1];
  assign req_other_s = DMEM_PRIO ? req_im_s : req_dm_s;

  // Address-phase owner: live arbitration when the bus advances, frozen while stalled.
  always_comb begin
    sel_s = OWN_NONE;
    if (m_hready_i) begin
      if (req_im_s && req_dm_s) begin
        if (starve_q == STARVE_LIM_C) begin
          sel_s = OTHER_SIDE;
        end else begin
          sel_s = PRIO_SIDE;
        end
      end else if (req_im_s) begin
        sel_s = OWN_IM;
      end else if (req_dm_s) begin
        sel_s = OWN_DM;
      end else begin
        sel_s = OWN_NONE;
      end
    end else begin
      sel_s = aphase_q;
    end
  end

  // Per-requester hready and detection of read data that must be parked.
  always_comb begin
    idle_im_s     = !req_im_s && (downer_q != OWN_IM) && !hold_im_q;
    idle_dm_s     = !req_dm_s && (downer_q != OWN_DM) && !hold_dm_q;
    im_hready_s   = idle_im_s ? 1'b1 : (m_hready_i && (!req_im_s || (sel_s == OWN_IM)));
    dm_hready_s   = idle_dm_s ? 1'b1 : (m_hready_i && (!req_dm_s || (sel_s == OWN_DM)));
    set_hold_im_s = (downer_q == OWN_IM) && m_hready_i && req_im_s && (sel_s != OWN_IM);
    set_hold_dm_s = (downer_q == OWN_DM) && m_hready_i && req_dm_s && (sel_s != OWN_DM);
  end

  // Next-state for ownership, starvation counter and parked read data.
  always_comb begin
    aphase_d      = aphase_q;
    downer_d      = downer_q;
    starve_d      = starve_q;
    hold_im_d     = hold_im_q;
    hold_dm_d     = hold_dm_q;
    cap_im_d      = cap_im_q;
    cap_dm_d      = cap_dm_q;
    cap_resp_im_d = cap_resp_im_q;
    cap_resp_dm_d = cap_resp_dm_q;

    if (m_hready_i) begin
      aphase_d = sel_s;
      downer_d = sel_s;
    end else begin
      aphase_d = aphase_q;
      downer_d = downer_q;
    end

    // A lone priority requester never builds up a starvation streak.
    if (!req_other_s) begin
      starve_d = 4'd0;
    end else if (m_hready_i) begin
      if (sel_s == PRIO_SIDE) begin
        starve_d = starve_q + 4'd1;
      end else begin
        starve_d = 4'd0;
      end
    end else begin
      starve_d = starve_q;
    end

    if (set_hold_im_s) begin
      hold_im_d     = 1'b1;
      cap_im_d      = m_hrdata_i;
      cap_resp_im_d = m_hresp_i;
    end else if (im_hready_s) begin
      hold_im_d = 1'b0;
    end else begin
      hold_im_d = hold_im_q;
    end

    if (set_hold_dm_s) begin
      hold_dm_d     = 1'b1;
      cap_dm_d      = m_hrdata_i;
      cap_resp_dm_d = m_hresp_i;
    end else if (dm_hready_s) begin
      hold_dm_d = 1'b0;
    end else begin
      hold_dm_d = hold_dm_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aphase_q      <= OWN_NONE;
      downer_q      <= OWN_NONE;
      starve_q      <= 4'd0;
      hold_im_q     <= 1'b0;
      hold_dm_q     <= 1'b0;
      cap_im_q      <= '0;
      cap_dm_q      <= '0;
      cap_resp_im_q <= 1'b0;
      cap_resp_dm_q <= 1'b0;
    end else begin
      aphase_q      <= aphase_d;
      downer_q      <= downer_d;
      starve_q      <= starve_d;
      hold_im_q     <= hold_im_d;
      hold_dm_q     <= hold_dm_d;
      cap_im_q      <= cap_im_d;
      cap_dm_q      <= cap_dm_d;
      cap_resp_im_q <= cap_resp_im_d;
      cap_resp_dm_q <= cap_resp_dm_d;
    end
  end

  // Manager port mux; forced idle while reset is asserted so the bus sees no transfer.
  always_comb begin
    m_haddr_o  = '0;
    m_htrans_o = HTRANS_IDLE;
    m_hwrite_o = 1'b0;
    m_hsize_o  = 3'b000;
    m_hprot_o  = 4'b0000;
    m_hwdata_o = '0;
    if (!rst_ni) begin
      m_htrans_o = HTRANS_IDLE;
    end else begin
      case (sel_s)
        OWN_IM: begin
          m_haddr_o  = im_haddr_i;
          m_htrans_o = im_htrans_i;
          m_hwrite_o = im_hwrite_i;
          m_hsize_o  = im_hsize_i;
          m_hprot_o  = im_hprot_i;
        end
        OWN_DM: begin
          m_haddr_o  = dm_haddr_i;
          m_htrans_o = dm_htrans_i;
          m_hwrite_o = dm_hwrite_i;
          m_hsize_o  = dm_hsize_i;
          m_hprot_o  = dm_hprot_i;
        end
        default: begin
          m_htrans_o = HTRANS_IDLE;
        end
      endcase
      case (downer_q)
        OWN_IM:  m_hwdata_o = im_hwdata_i;
        OWN_DM:  m_hwdata_o = dm_hwdata_i;
        default: m_hwdata_o = '0;
      endcase
    end
  end

  // Requester-side response routing; parked data wins over the live bus.
  always_comb begin
    im_hready_o = 1'b1;
    dm_hready_o = 1'b1;
    im_hrdata_o = '0;
    dm_hrdata_o = '0;
    im_hresp_o  = 1'b0;
    dm_hresp_o  = 1'b0;
    if (!rst_ni) begin
      im_hready_o = 1'b1;
      dm_hready_o = 1'b1;
    end else begin
      im_hready_o = im_hready_s;
      dm_hready_o = dm_hready_s;
      if (hold_im_q) begin
        im_hrdata_o = cap_im_q;
        im_hresp_o  = cap_resp_im_q;
      end else begin
        im_hrdata_o = m_hrdata_i;
        im_hresp_o  = (downer_q == OWN_IM) ? m_hresp_i : 1'b0;
      end
      if (hold_dm_q) begin
        dm_hrdata_o = cap_dm_q;
        dm_hresp_o  = cap_resp_dm_q;
      end else begin
        dm_hrdata_o = m_hrdata_i;
        dm_hresp_o  = (downer_q == OWN_DM) ? m_hresp_i : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rv0_ahb_arb.sv
// tb_rv0_ahb_arb: directed scenarios followed by randomized traffic, all
// checked every cycle against a transaction-level ownership model.
module tb_rv0_ahb_arb;

  localparam bit PRIO = 1'b1;
  localparam int SLIM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] im_haddr, dm_haddr, im_hwdata, dm_hwdata;
  logic [1:0]  im_htrans, dm_htrans;
  logic        im_hwrite, dm_hwrite;
  logic [2:0]  im_hsize, dm_hsize;
  logic [3:0]  im_hprot, dm_hprot;
  logic        im_hready, dm_hready, im_hresp, dm_hresp;
  logic [31:0] im_hrdata, dm_hrdata;
  logic [31:0] m_haddr, m_hwdata, m_hrdata;
  logic [1:0]  m_htrans;
  logic        m_hwrite, m_hready, m_hresp;
  logic [2:0]  m_hsize;
  logic [3:0]  m_hprot;

  rv0_ahb_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DMEM_PRIO(PRIO), .STARVE_LIM(SLIM)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .im_haddr_i(im_haddr), .im_htrans_i(im_htrans), .im_hwrite_i(im_hwrite),
    .im_hsize_i(im_hsize), .im_hprot_i(im_hprot), .im_hwdata_i(im_hwdata),
    .im_hready_o(im_hready), .im_hrdata_o(im_hrdata), .im_hresp_o(im_hresp),
    .dm_haddr_i(dm_haddr), .dm_htrans_i(dm_htrans), .dm_hwrite_i(dm_hwrite),
    .dm_hsize_i(dm_hsize), .dm_hprot_i(dm_hprot), .dm_hwdata_i(dm_hwdata),
    .dm_hready_o(dm_hready), .dm_hrdata_o(dm_hrdata), .dm_hresp_o(dm_hresp),
    .m_haddr_o(m_haddr), .m_htrans_o(m_htrans), .m_hwrite_o(m_hwrite),
    .m_hsize_o(m_hsize), .m_hprot_o(m_hprot), .m_hwdata_o(m_hwdata),
    .m_hready_i(m_hready), .m_hrdata_i(m_hrdata), .m_hresp_i(m_hresp)
  );

  int checks_cnt = 0;
  int errors_cnt = 0;

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: requester index 0=IM, 1=DM, -1=nobody.
  int          m_ap, m_dp, m_streak;
  bit          m_park [2];
  logic [31:0] m_pdata [2];
  logic        m_perr [2];
  bit          last_rdy [2];

  task automatic model_reset();
    m_ap = -1; m_dp = -1; m_streak = 0;
    for (int x = 0; x < 2; x++) begin
      m_park[x] = 1'b0; m_pdata[x] = 32'h0; m_perr[x] = 1'b0; last_rdy[x] = 1'b1;
    end
  endtask

  task automatic drv_im(input logic [1:0] t, input logic [31:0] a, input logic w);
    im_htrans = t; im_haddr = a; im_hwrite = w;
    im_hsize = 3'($urandom_range(0, 2)); im_hprot = 4'($urandom_range(0, 15));
  endtask

  task automatic drv_dm(input logic [1:0] t, input logic [31:0] a, input logic w);
    dm_htrans = t; dm_haddr = a; dm_hwrite = w;
    dm_hsize = 3'($urandom_range(0, 2)); dm_hprot = 4'($urandom_range(0, 15));
  endtask

  // One bus cycle: compare outputs at the falling edge, advance the model at the rising edge.
  task automatic step();
    bit          req [2];
    bit          rdy [2];
    int          win, pri, np;
    logic [31:0] e_addr, e_wdata;
    logic [1:0]  e_trans;
    logic        e_wr;
    logic [2:0]  e_size;
    logic [3:0]  e_prot;
    logic [31:0] e_rdata [2];
    logic        e_resp [2];
    logic [31:0] o_rdata [2];
    logic        o_resp [2];
    logic        o_rdy [2];
    @(negedge clk);
    req[0] = im_htrans[1];
    req[1] = dm_htrans[1];
    pri = PRIO ? 1 : 0;
    np  = 1 - pri;
    if (m_hready) begin
      if (req[0] && req[1])  win = (m_streak == SLIM) ? np : pri;
      else if (req[0])       win = 0;
      else if (req[1])       win = 1;
      else                   win = -1;
    end else begin
      win = m_ap;
    end
    e_addr = 32'h0; e_trans = 2'b00; e_wr = 1'b0; e_size = 3'b000; e_prot = 4'b0000;
    if (win == 0) begin
      e_addr = im_haddr; e_trans = im_htrans; e_wr = im_hwrite; e_size = im_hsize; e_prot = im_hprot;
    end else if (win == 1) begin
      e_addr = dm_haddr; e_trans = dm_htrans; e_wr = dm_hwrite; e_size = dm_hsize; e_prot = dm_hprot;
    end
    e_wdata = (m_dp == 0) ? im_hwdata : ((m_dp == 1) ? dm_hwdata : 32'h0);
    o_rdata[0] = im_hrdata; o_rdata[1] = dm_hrdata;
    o_resp[0]  = im_hresp;  o_resp[1]  = dm_hresp;
    o_rdy[0]   = im_hready; o_rdy[1]   = dm_hready;
    for (int x = 0; x < 2; x++) begin
      rdy[x]     = (!req[x] && m_dp != x && !m_park[x]) || (m_hready && (!req[x] || win == x));
      e_rdata[x] = m_park[x] ? m_pdata[x] : m_hrdata;
      e_resp[x]  = m_park[x] ? m_perr[x] : ((m_dp == x) ? m_hresp : 1'b0);
      chk_val(x == 0 ? "im_hready" : "dm_hready", 64'(o_rdy[x]), 64'(rdy[x]));
      chk_val(x == 0 ? "im_hrdata" : "dm_hrdata", 64'(o_rdata[x]), 64'(e_rdata[x]));
      chk_val(x == 0 ? "im_hresp" : "dm_hresp", 64'(o_resp[x]), 64'(e_resp[x]));
    end
    chk_val("m_haddr", 64'(m_haddr), 64'(e_addr));
    chk_val("m_htrans", 64'(m_htrans), 64'(e_trans));
    chk_val("m_hwrite", 64'(m_hwrite), 64'(e_wr));
    chk_val("m_hsize", 64'(m_hsize), 64'(e_size));
    chk_val("m_hprot", 64'(m_hprot), 64'(e_prot));
    chk_val("m_hwdata", 64'(m_hwdata), 64'(e_wdata));
    @(posedge clk);
    for (int x = 0; x < 2; x++) begin
      if (m_hready && m_dp == x && req[x] && win != x) begin
        m_park[x] = 1'b1; m_pdata[x] = m_hrdata; m_perr[x] = m_hresp;
      end else if (rdy[x]) begin
        m_park[x] = 1'b0;
      end
    end
    if (!req[np])          m_streak = 0;
    else if (m_hready)     m_streak = (win == pri) ? m_streak + 1 : 0;
    if (m_hready) begin
      m_ap = win; m_dp = win;
    end
    last_rdy[0] = rdy[0];
    last_rdy[1] = rdy[1];
    #1;
  endtask

  task automatic all_idle();
    drv_im(2'b00, 32'h0, 1'b0);
    drv_dm(2'b00, 32'h0, 1'b0);
    m_hready = 1'b1; m_hresp = 1'b0;
  endtask

  logic [31:0] seq_exp [6];
  logic [31:0] dm_a;
  int          pct;
  bit          err2;

  initial begin
    model_reset();
    // Reset state with traffic present on the inputs.
    drv_im(2'b10, 32'h1234_0000, 1'b0);
    drv_dm(2'b00, 32'h0, 1'b0);
    im_hwdata = 32'h5555_5555; dm_hwdata = 32'h6666_6666;
    m_hready = 1'b1; m_hrdata = 32'hFFFF_FFFF; m_hresp = 1'b1;
    #2;
    chk_val("rst_htrans", 64'(m_htrans), 64'(2'b00));
    chk_val("rst_haddr", 64'(m_haddr), 64'(32'h0));
    chk_val("rst_hwdata", 64'(m_hwdata), 64'(32'h0));
    chk_val("rst_im_hready", 64'(im_hready), 64'(1'b1));
    chk_val("rst_dm_hready", 64'(dm_hready), 64'(1'b1));
    chk_val("rst_im_hrdata", 64'(im_hrdata), 64'(32'h0));
    chk_val("rst_im_hresp", 64'(im_hresp), 64'(1'b0));
    all_idle();
    m_hrdata = 32'h0;
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Lone IM read, zero wait states.
    drv_im(2'b10, 32'h0010_0000, 1'b0);
    #1;
    chk_val("t1_haddr", 64'(m_haddr), 64'(32'h0010_0000));
    chk_val("t1_im_hready", 64'(im_hready), 64'(1'b1));
    step();
    drv_im(2'b00, 32'h0, 1'b0); m_hrdata = 32'hDEAD_BEEF;
    #1;
    chk_val("t1_im_hrdata", 64'(im_hrdata), 64'(32'hDEAD_BEEF));
    chk_val("t1_im_hready2", 64'(im_hready), 64'(1'b1));
    chk_val("t1_dm_hready", 64'(dm_hready), 64'(1'b1));
    step();

    // Simultaneous requests: DM first, IM next.
    drv_im(2'b10, 32'h0000_0200, 1'b0);
    drv_dm(2'b10, 32'h0000_0300, 1'b0);
    #1;
    chk_val("t2_haddr_dm", 64'(m_haddr), 64'(32'h0000_0300));
    chk_val("t2_im_hready", 64'(im_hready), 64'(1'b0));
    step();
    drv_dm(2'b00, 32'h0, 1'b0);
    #1;
    chk_val("t2_haddr_im", 64'(m_haddr), 64'(32'h0000_0200));
    step();
    all_idle(); step(); step();

    // IM read completes while its next fetch loses to DM: data is parked.
    drv_im(2'b10, 32'h0000_0400, 1'b0);
    step();
    drv_im(2'b10, 32'h0000_0404, 1'b0);
    drv_dm(2'b10, 32'h0000_0500, 1'b1);
    m_hrdata = 32'h1234_5678;
    #1;
    chk_val("t3_im_hready_lo", 64'(im_hready), 64'(1'b0));
    step();
    drv_dm(2'b00, 32'h0, 1'b0);
    m_hrdata = 32'hAAAA_5555;
    #1;
    chk_val("t3_im_hready_hi", 64'(im_hready), 64'(1'b1));
    chk_val("t3_im_hrdata", 64'(im_hrdata), 64'(32'h1234_5678));
    step();
    all_idle(); step(); step();

    // Starvation limit: four DM grants, one IM grant, DM resumes.
    seq_exp[0] = 32'h600; seq_exp[1] = 32'h604; seq_exp[2] = 32'h608;
    seq_exp[3] = 32'h60C; seq_exp[4] = 32'h700; seq_exp[5] = 32'h610;
    dm_a = 32'h600;
    for (int i = 0; i < 6; i++) begin
      if (i > 0 && last_rdy[1]) dm_a = dm_a + 32'd4;
      drv_dm(2'b10, dm_a, 1'b0);
      if (i == 0 || !last_rdy[0]) drv_im(2'b10, 32'h700, 1'b0);
      else drv_im(2'b00, 32'h0, 1'b0);
      #1;
      chk_val($sformatf("t4_haddr%0d", i), 64'(m_haddr), 64'(seq_exp[i]));
      step();
    end
    all_idle(); step(); step();

    // Two-cycle ERROR on a DM write.
    drv_dm(2'b10, 32'h0000_0800, 1'b1);
    step();
    drv_dm(2'b00, 32'h0, 1'b0); m_hready = 1'b0; m_hresp = 1'b1;
    #1;
    chk_val("t5_dm_hresp1", 64'(dm_hresp), 64'(1'b1));
    chk_val("t5_dm_hready1", 64'(dm_hready), 64'(1'b0));
    chk_val("t5_im_hready1", 64'(im_hready), 64'(1'b1));
    chk_val("t5_im_hresp1", 64'(im_hresp), 64'(1'b0));
    step();
    m_hready = 1'b1; m_hresp = 1'b1;
    #1;
    chk_val("t5_dm_hresp2", 64'(dm_hresp), 64'(1'b1));
    chk_val("t5_dm_hready2", 64'(dm_hready), 64'(1'b1));
    step();
    all_idle(); step();

    // Reset asserted in the middle of a stalled transfer.
    drv_dm(2'b10, 32'h0000_0900, 1'b0);
    step();
    drv_dm(2'b10, 32'h0000_0904, 1'b0);
    drv_im(2'b10, 32'h0000_0A00, 1'b0);
    m_hready = 1'b0; m_hrdata = 32'hCAFE_F00D;
    #2 rst_n = 1'b0;
    #1;
    chk_val("t6_htrans", 64'(m_htrans), 64'(2'b00));
    chk_val("t6_haddr", 64'(m_haddr), 64'(32'h0));
    chk_val("t6_im_hready", 64'(im_hready), 64'(1'b1));
    chk_val("t6_dm_hready", 64'(dm_hready), 64'(1'b1));
    chk_val("t6_dm_hrdata", 64'(dm_hrdata), 64'(32'h0));
    @(posedge clk);
    @(negedge clk);
    all_idle();
    m_hrdata = 32'h0;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;

    // Randomized traffic from two well-behaved AHB managers and a random completer.
    err2 = 1'b0;
    pct  = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) pct = $urandom_range(10, 100);
      if (err2) begin
        m_hready = 1'b1; m_hresp = 1'b1; err2 = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        m_hready = 1'b0; m_hresp = 1'b1; err2 = 1'b1;
      end else begin
        m_hready = ($urandom_range(0, 3) != 0); m_hresp = 1'b0;
      end
      m_hrdata  = $urandom;
      im_hwdata = $urandom;
      dm_hwdata = $urandom;
      if (!(im_htrans[1] && !last_rdy[0])) begin
        if ($urandom_range(0, 99) < pct) drv_im($urandom_range(0, 1) ? 2'b10 : 2'b11, $urandom, 1'($urandom_range(0, 1)));
        else drv_im(2'($urandom_range(0, 1)), $urandom, 1'b0);
      end
      if (!(dm_htrans[1] && !last_rdy[1])) begin
        if ($urandom_range(0, 99) < pct) drv_dm($urandom_range(0, 1) ? 2'b10 : 2'b11, $urandom, 1'($urandom_range(0, 1)));
        else drv_dm(2'($urandom_range(0, 1)), $urandom, 1'b0);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
